// File: rtl/encoder_10b8b_decoder.sv
// 8b/10b receive decoder: registered byte/K/error outputs, running disparity
// tracking and a comma-based LOSS/ACQ/SYNC word-alignment monitor (falling-edge clocked).
module encoder_10b8b_decoder #(
  parameter int SYNC_COMMAS = 3,
  parameter int LOSS_ERRS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic [9:0] entradas,
  output logic [7:0] salidas,
  output logic       K,
  output logic       code_err,
  output logic       disp_err,
  output logic       comma,
  output logic       rd,
  output logic       sync
);

  localparam int ACQ_W = (SYNC_COMMAS < 2) ? 1 : $clog2(SYNC_COMMAS + 1);
  localparam int ERR_W = (LOSS_ERRS < 2) ? 1 : $clog2(LOSS_ERRS + 1);
  localparam logic [ACQ_W-1:0] ACQ_TGT = ACQ_W'(SYNC_COMMAS);
  localparam logic [ERR_W-1:0] ERR_TGT = ERR_W'(LOSS_ERRS);

  typedef enum logic [1:0] {LOSS, ACQ, SYNC} state_t;

  state_t           state_q, state_d;
  logic [ACQ_W-1:0] acq_cnt_q, acq_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       salidas_q, salidas_d;
  logic             k_q, k_d, code_err_q, code_err_d, disp_err_q, disp_err_d;
  logic             comma_q, comma_d, rd_q, rd_d, sync_q, sync_d;

  logic [5:0] six;
  logic [3:0] four_raw, four_eff;
  logic [4:0] x5;
  logic [2:0] y3;
  logic       v6, v4, k28, k7, a7, a7_d_ok, bad_p7, is_k;
  logic       p6, n6, p4, n4, rd_mid, word_code_err, word_disp_err, word_comma;

  // Sub-blocks rearranged into transmission order (abcdei, fghj) so the tables read naturally.
  assign six      = {entradas[0], entradas[1], entradas[2], entradas[3], entradas[4], entradas[5]};
  assign four_raw = {entradas[6], entradas[7], entradas[8], entradas[9]};
  // K28 sent with a negative 6b uses complemented balanced 4b codes.
  assign four_eff = (six == 6'b110000) ? ~four_raw : four_raw;

  always_comb begin
    x5  = 5'd0;
    v6  = 1'b1;
    k28 = 1'b0;
    k7  = 1'b0;
    case (six)
      6'b100111, 6'b011000: x5 = 5'd0;
      6'b011101, 6'b100010: x5 = 5'd1;
      6'b101101, 6'b010010: x5 = 5'd2;
      6'b110001:            x5 = 5'd3;
      6'b110101, 6'b001010: x5 = 5'd4;
      6'b101001:            x5 = 5'd5;
      6'b011001:            x5 = 5'd6;
      6'b111000, 6'b000111: x5 = 5'd7;
      6'b111001, 6'b000110: x5 = 5'd8;
      6'b100101:            x5 = 5'd9;
      6'b010101:            x5 = 5'd10;
      6'b110100:            x5 = 5'd11;
      6'b001101:            x5 = 5'd12;
      6'b101100:            x5 = 5'd13;
      6'b011100:            x5 = 5'd14;
      6'b010111, 6'b101000: x5 = 5'd15;
      6'b011011, 6'b100100: x5 = 5'd16;
      6'b100011:            x5 = 5'd17;
      6'b010011:            x5 = 5'd18;
      6'b110010:            x5 = 5'd19;
      6'b001011:            x5 = 5'd20;
      6'b101010:            x5 = 5'd21;
      6'b011010:            x5 = 5'd22;
      6'b111010, 6'b000101: begin x5 = 5'd23; k7 = 1'b1; end
      6'b110011, 6'b001100: x5 = 5'd24;
      6'b100110:            x5 = 5'd25;
      6'b010110:            x5 = 5'd26;
      6'b110110, 6'b001001: begin x5 = 5'd27; k7 = 1'b1; end
      6'b001110:            x5 = 5'd28;
      6'b101110, 6'b010001: begin x5 = 5'd29; k7 = 1'b1; end
      6'b011110, 6'b100001: begin x5 = 5'd30; k7 = 1'b1; end
      6'b101011, 6'b010100: x5 = 5'd31;
      6'b001111, 6'b110000: begin x5 = 5'd28; k28 = 1'b1; end
      default:              v6 = 1'b0;
    endcase
  end

  always_comb begin
    y3 = 3'd0;
    v4 = 1'b1;
    case (four_eff)
      4'b1011, 4'b0100:                   y3 = 3'd0;
      4'b1001:                            y3 = 3'd1;
      4'b0101:                            y3 = 3'd2;
      4'b1100, 4'b0011:                   y3 = 3'd3;
      4'b1101, 4'b0010:                   y3 = 3'd4;
      4'b1010:                            y3 = 3'd5;
      4'b0110:                            y3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: y3 = 3'd7;
      default:                            v4 = 1'b0;
    endcase
  end

  // Alternate-7 codes are legal only after D17/18/20, D11/13/14 or a control 6b;
  // primary-7 codes must not extend a run of equal e,i bits.
  always_comb begin
    a7      = (four_raw == 4'b0111) || (four_raw == 4'b1000);
    a7_d_ok = ((four_raw == 4'b0111) && ((six == 6'b100011) || (six == 6'b010011) || (six == 6'b001011))) ||
              ((four_raw == 4'b1000) && ((six == 6'b110100) || (six == 6'b101100) || (six == 6'b011100)));
    bad_p7  = ((four_raw == 4'b1110) && (six[1:0] == 2'b11)) ||
              ((four_raw == 4'b0001) && (six[1:0] == 2'b00));
    is_k    = k28 || (k7 && a7);
    word_code_err = !v6 || !v4 || bad_p7 || (a7 && !(k28 || k7 || a7_d_ok));

    p6     = ($countones(six) == 4);
    n6     = ($countones(six) == 2);
    p4     = ($countones(four_raw) == 3);
    n4     = ($countones(four_raw) == 1);
    rd_mid = p6 ? 1'b1 : (n6 ? 1'b0 : rd_q);
    rd_d   = p4 ? 1'b1 : (n4 ? 1'b0 : rd_mid);
    word_disp_err = !word_code_err &&
                    ((p6 && rd_q) || (n6 && !rd_q) || (p4 && rd_mid) || (n4 && !rd_mid));
    word_comma    = !word_code_err && k28 && ((y3 == 3'd1) || (y3 == 3'd5) || (y3 == 3'd7));

    salidas_d  = word_code_err ? 8'h00 : {y3, x5};
    k_d        = !word_code_err && is_k;
    code_err_d = word_code_err;
    disp_err_d = word_disp_err;
    comma_d    = word_comma;
  end

  // Alignment monitor; an error on a comma word counts as an error, not a comma.
  always_comb begin
    state_d   = state_q;
    acq_cnt_d = acq_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      LOSS: begin
        if (!word_code_err && !word_disp_err && word_comma) begin
          if (SYNC_COMMAS <= 1) begin
            state_d = SYNC;
          end else begin
            state_d   = ACQ;
            acq_cnt_d = ACQ_W'(1);
          end
        end
      end
      ACQ: begin
        if (word_code_err || word_disp_err) begin
          state_d   = LOSS;
          acq_cnt_d = '0;
        end else if (word_comma) begin
          if (acq_cnt_q + ACQ_W'(1) >= ACQ_TGT) begin
            state_d   = SYNC;
            acq_cnt_d = '0;
          end else begin
            acq_cnt_d = acq_cnt_q + ACQ_W'(1);
          end
        end
      end
      SYNC: begin
        if (word_code_err || word_disp_err) begin
          if (err_cnt_q + ERR_W'(1) >= ERR_TGT) begin
            state_d   = LOSS;
            err_cnt_d = '0;
          end else begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end else begin
          err_cnt_d = '0;
        end
      end
      default: begin
        state_d   = LOSS;
        acq_cnt_d = '0;
        err_cnt_d = '0;
      end
    endcase
    sync_d = (state_d == SYNC);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q    <= LOSS;
      acq_cnt_q  <= '0;
      err_cnt_q  <= '0;
      salidas_q  <= 8'h00;
      k_q        <= 1'b0;
      code_err_q <= 1'b0;
      disp_err_q <= 1'b0;
      comma_q    <= 1'b0;
      rd_q       <= 1'b0;
      sync_q     <= 1'b0;
    end else if (enb) begin
      state_q    <= state_d;
      acq_cnt_q  <= acq_cnt_d;
      err_cnt_q  <= err_cnt_d;
      salidas_q  <= salidas_d;
      k_q        <= k_d;
      code_err_q <= code_err_d;
      disp_err_q <= disp_err_d;
      comma_q    <= comma_d;
      rd_q       <= rd_d;
      sync_q     <= sync_d;
    end
  end

  assign salidas  = salidas_q;
  assign K        = k_q;
  assign code_err = code_err_q;
  assign disp_err = disp_err_q;
  assign comma    = comma_q;
  assign rd       = rd_q;
  assign sync     = sync_q;

endmodule

// File: tb/tb_encoder_10b8b_decoder.sv
// Directed bench for encoder_10b8b_decoder: hand-computed code groups, disparity,
// enable hold, reset priority and sync acquisition/loss.
module tb_encoder_10b8b_decoder;

  logic       clk;
  logic       reset;
  logic       enb;
  logic [9:0] entradas;
  logic [7:0] salidas;
  logic       K, code_err, disp_err, comma, rd, sync;

  int checkCount;
  int errorCount;

  encoder_10b8b_decoder #(.SYNC_COMMAS(3), .LOSS_ERRS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .enb      (enb),
    .entradas (entradas),
    .salidas  (salidas),
    .K        (K),
    .code_err (code_err),
    .disp_err (disp_err),
    .comma    (comma),
    .rd       (rd),
    .sync     (sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive on the rising edge, let the DUT update on the falling edge, sample just after.
  task automatic applyStimulus(input logic [9:0] word, input logic en, input logic rst);
    @(posedge clk);
    entradas = word;
    enb      = en;
    reset    = rst;
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkWord(input string tag, input logic [7:0] expByte, input logic expK,
                           input logic expCode, input logic expDisp, input logic expComma,
                           input logic expRd);
    checkOutput({tag, ".salidas"}, 16'(salidas), 16'(expByte));
    checkOutput({tag, ".K"}, 16'(K), 16'(expK));
    checkOutput({tag, ".code_err"}, 16'(code_err), 16'(expCode));
    checkOutput({tag, ".disp_err"}, 16'(disp_err), 16'(expDisp));
    checkOutput({tag, ".comma"}, 16'(comma), 16'(expComma));
    checkOutput({tag, ".rd"}, 16'(rd), 16'(expRd));
  endtask

  logic [9:0] holdWords [5];

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    enb        = 1'b1;
    entradas   = 10'h17C;
    holdWords  = '{10'h17C, 10'h000, 10'h283, 10'h3B1, 10'h1F1};

    // Reset wins over a valid comma on the input.
    applyStimulus(10'h17C, 1'b1, 1'b1);
    checkWord("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.sync", 16'(sync), 16'h0);

    applyStimulus(10'h17C, 1'b1, 1'b0);
    checkWord("k28_5_neg", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("k28_5_neg.sync", 16'(sync), 16'h0);

    applyStimulus(10'h17C, 1'b1, 1'b0);
    checkWord("k28_5_repeat", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    applyStimulus(10'h000, 1'b1, 1'b1);
    applyStimulus(10'h0B9, 1'b1, 1'b0);
    checkWord("d0_0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(10'h000, 1'b1, 1'b0);
    checkWord("all_zero", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus(10'h155, 1'b1, 1'b0);
    checkWord("d21_5", 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(10'h07C, 1'b1, 1'b0);
    checkWord("k28_7", 8'hFC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus(10'h057, 1'b1, 1'b0);
    checkWord("k23_7", 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(10'h3B1, 1'b1, 1'b0);
    checkWord("d17_a7", 8'hF1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(10'h1F1, 1'b1, 1'b0);
    checkOutput("d17_p7.code_err", 16'(code_err), 16'h1);
    checkOutput("d17_p7.salidas", 16'(salidas), 16'h00);
    checkOutput("d17_p7.K", 16'(K), 16'h0);

    applyStimulus(10'h04B, 1'b1, 1'b0);
    checkWord("d11_a7", 8'hEB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(holdWords[i], 1'b0, 1'b0);
      checkWord($sformatf("hold%0d", i), 8'hEB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("hold%0d.sync", i), 16'(sync), 16'h0);
    end
    applyStimulus(10'h17C, 1'b1, 1'b0);
    checkWord("after_hold", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Acquire with alternating-disparity commas.
    applyStimulus(10'h000, 1'b1, 1'b1);
    applyStimulus(10'h17C, 1'b1, 1'b0);
    checkOutput("acq1.sync", 16'(sync), 16'h0);
    applyStimulus(10'h283, 1'b1, 1'b0);
    checkWord("k28_5_pos", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("acq2.sync", 16'(sync), 16'h0);
    applyStimulus(10'h17C, 1'b1, 1'b0);
    checkOutput("acq3.sync", 16'(sync), 16'h1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(10'h000, 1'b1, 1'b0);
      checkOutput($sformatf("err%0d.sync", i + 1), 16'(sync), 16'h1);
    end
    applyStimulus(10'h283, 1'b1, 1'b0);
    checkOutput("good_after3.sync", 16'(sync), 16'h1);
    checkOutput("good_after3.disp_err", 16'(disp_err), 16'h0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(10'h000, 1'b1, 1'b0);
      checkOutput($sformatf("loss%0d.sync", i + 1), 16'(sync), (i == 3) ? 16'h0 : 16'h1);
    end

    // Reset mid-acquisition discards the comma count.
    applyStimulus(10'h000, 1'b1, 1'b1);
    applyStimulus(10'h17C, 1'b1, 1'b0);
    applyStimulus(10'h283, 1'b1, 1'b0);
    applyStimulus(10'h17C, 1'b0, 1'b1);
    checkOutput("reset_acq.sync", 16'(sync), 16'h0);
    checkOutput("reset_acq.rd", 16'(rd), 16'h0);
    applyStimulus(10'h17C, 1'b1, 1'b0);
    checkOutput("reacq1.sync", 16'(sync), 16'h0);
    applyStimulus(10'h283, 1'b1, 1'b0);
    checkOutput("reacq2.sync", 16'(sync), 16'h0);
    applyStimulus(10'h17C, 1'b1, 1'b0);
    checkOutput("reacq3.sync", 16'(sync), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/encoder_10b8b_decoder.md
ENCODER_10B8B_DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter SYNC_COMMAS, default 3: number of error-free commas needed to reach SYNC.
REQ-002 Parameter LOSS_ERRS, default 4: number of consecutive bad words that forces LOSS.
REQ-003 clk  input  1  single clock; all state updates on the falling edge of clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enb  input  1  word-valid enable; state and outputs update only on edges with enb=1.
REQ-006 entradas  input  10  received code group, bit order j h g f i e d c b a = [9:0].
REQ-007 salidas  output  8  decoded byte, bit order H G F E D C B A = [7:0].
REQ-008 K  output  1  decoded word is a control (K) character.
REQ-009 code_err  output  1  current word is not a valid 10b code group.
REQ-010 disp_err  output  1  current word is valid but illegal for the current running disparity.
REQ-011 comma  output  1  current word is K28.1, K28.5 or K28.7.
REQ-012 rd  output  1  running disparity after the current word (0 = negative, 1 = positive).
REQ-013 sync  output  1  block is in state SYNC.

Function
REQ-014 The block SHALL decode the 6b sub-block (abcdei) to EDCBA and the 4b sub-block (fghj) to HGF per the standard 8b/10b 5b/6b and 3b/4b tables, including both RD columns and the D.x.A7 alternate.
REQ-015 All outputs SHALL be registered; latency is exactly one enabled falling edge from entradas to salidas/K/flags.
REQ-016 With enb=0 every output and internal state SHALL hold its value.
REQ-017 K SHALL be 1 only for the 12 valid control groups (K28.0-K28.7, K23.7, K27.7, K29.7, K30.7).
REQ-018 code_err SHALL be 1 for any sub-block absent from the tables, for sub-block disparity other than 0/+2/-2, or for an illegal 6b/4b combination; salidas then holds 8'h00 and K=0.
REQ-019 disp_err SHALL be 1 when a nonzero-disparity sub-block has the same sign as the running disparity preceding it (6b checked against rd, 4b against RD after 6b).
REQ-020 RD update: a sub-block of disparity +2 sets RD positive, -2 sets negative, 0 leaves it; applied to 6b then 4b, also on erroneous words (RD follows the received data).
REQ-021 Sync FSM states: LOSS, ACQ, SYNC.
REQ-022 LOSS -> ACQ on a comma without code_err/disp_err; counter set to 1.
REQ-023 ACQ: each error-free comma increments the counter; counter reaching SYNC_COMMAS -> SYNC; any errored word -> LOSS; error-free non-comma words hold state and counter.
REQ-024 SYNC: each errored word increments an error counter, any error-free word clears it; counter reaching LOSS_ERRS -> LOSS.
REQ-025 Counters SHALL be wide enough for their parameters and SHALL never wrap.
REQ-026 If a comma and an error occur on the same word, the error SHALL take priority for FSM transitions.
REQ-027 sync SHALL be 1 from the edge on which SYNC is entered until the edge on which it is left.

Reset
REQ-028 On reset=1 at a falling edge (regardless of enb): salidas=8'h00, K=0, code_err=0, disp_err=0, comma=0, rd=0, sync=0, FSM=LOSS, all counters 0.
REQ-029 Reset asserted mid-acquisition or mid-SYNC SHALL discard all progress; reset has priority over enb.

Verification
REQ-030 After reset, entradas=10'h17C (K28.5, RD-) -> next edge: salidas=8'hBC, K=1, comma=1, rd=1, no errors.
REQ-031 From rd=0, entradas=10'h0B9 (D0.0) -> salidas=8'h00, K=0, rd=0, no errors.
REQ-032 10'h17C twice in a row -> second word: disp_err=1, code_err=0, salidas=8'hBC, K=1, rd=1.
REQ-033 entradas=10'h000 -> code_err=1, salidas=8'h00, K=0.
REQ-034 Alternating 10'h17C/10'h283 (K28.5 RD-/RD+) for 3 words -> sync=1 after the 3rd enabled edge; then 4 consecutive 10'h000 -> sync=0 on the 4th; a good word after only 3 errors keeps sync=1.
REQ-035 Hold enb=0 for 5 edges with changing entradas -> all outputs unchanged; reset asserted during ACQ -> sync=0, rd=0, and 3 new commas are required to reach SYNC.
